// File: rtl/axis_s_pkt_assembler_if.sv
// Byte-stream input and assembled-packet output bundle for axis_s_pkt_assembler.
// The slave modport is the assembler's view; master is the view of whoever drives it.
interface axis_s_pkt_assembler_if #(
    parameter int PKT_BYTES = 4
);
    logic                   s_axis_tvalid;
    logic [7:0]             s_axis_tdata;
    logic                   s_axis_tlast;
    logic                   s_axis_tready;
    logic                   pkt_valid;
    logic [8*PKT_BYTES-1:0] pkt_data;
    logic [3:0]             pkt_len;
    logic                   pkt_err;
    logic                   pkt_ready;
    logic [7:0]             err_cnt;

    modport slave (
        input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, pkt_ready,
        output s_axis_tready, pkt_valid, pkt_data, pkt_len, pkt_err, err_cnt
    );

    modport master (
        output s_axis_tvalid, s_axis_tdata, s_axis_tlast, pkt_ready,
        input  s_axis_tready, pkt_valid, pkt_data, pkt_len, pkt_err, err_cnt
    );
endinterface

// File: rtl/axis_s_pkt_assembler.sv
// Packs an 8-bit stream into PKT_BYTES-wide little-endian packets, flags framing
// errors, and queues the results in a small first-word-fall-through FIFO.
//
// state      | meaning
// -----------+-----------------------------------------------
// S_IDLE     | no bytes held, next accepted byte is byte 0
// S_ASSEMBLE | 1..PKT_BYTES-1 bytes held in asm_q
// S_DISCARD  | full packet already pushed, dropping tail to tlast
module axis_s_pkt_assembler #(
    parameter int PKT_BYTES  = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     s_axis_aclk,
    input  logic                     s_axis_aresetn,
    axis_s_pkt_assembler_if.slave    bus
);
    localparam int DW = 8 * PKT_BYTES;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [3:0]    LAST_IDX = 4'(PKT_BYTES - 1);
    localparam logic [3:0]    FULL_LEN = 4'(PKT_BYTES);
    localparam logic [AW-1:0] PTR_MAX  = AW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ASSEMBLE, S_DISCARD} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [DW-1:0] asm_q, asm_d, wr_data;
    logic          push, push_err;
    logic [3:0]    push_len;
    logic          accept, pop, full;
    logic [7:0]    err_q;

    logic [DW-1:0] mem_data [FIFO_DEPTH];
    logic [3:0]    mem_len  [FIFO_DEPTH];
    logic          mem_err  [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] occ;

    assign full   = (occ == DEPTH_C);
    // Held low through reset; otherwise a function of registered state only.
    assign bus.s_axis_tready = s_axis_aresetn & ((state_q == S_DISCARD) | ~full);
    assign accept = bus.s_axis_tvalid & bus.s_axis_tready;
    assign pop    = (occ != '0) & bus.pkt_ready;

    always_comb begin
        wr_data = asm_q;
        for (int k = 0; k < PKT_BYTES; k++) begin
            if (cnt_q == 4'(k)) wr_data[8*k +: 8] = bus.s_axis_tdata;
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            asm_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        asm_d    = asm_q;
        push     = 1'b0;
        push_len = '0;
        push_err = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (bus.s_axis_tlast) begin
                        push     = 1'b1;
                        push_len = 4'd1;
                        push_err = 1'b1;
                        cnt_d    = '0;
                        asm_d    = '0;
                    end else begin
                        state_d = S_ASSEMBLE;
                        cnt_d   = 4'd1;
                        asm_d   = wr_data;
                    end
                end
            end
            S_ASSEMBLE: begin
                if (accept) begin
                    if (bus.s_axis_tlast) begin
                        push     = 1'b1;
                        push_len = cnt_q + 4'd1;
                        push_err = ((cnt_q + 4'd1) != FULL_LEN);
                        state_d  = S_IDLE;
                        cnt_d    = '0;
                        asm_d    = '0;
                    end else if (cnt_q == LAST_IDX) begin
                        push     = 1'b1;
                        push_len = FULL_LEN;
                        push_err = 1'b1;
                        state_d  = S_DISCARD;
                        cnt_d    = '0;
                        asm_d    = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                        asm_d = wr_data;
                    end
                end
            end
            S_DISCARD: begin
                if (accept && bus.s_axis_tlast) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                asm_d   = '0;
            end
        endcase
    end

    // Storage is cleared on reset so the head reads as zero while empty after reset.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_len[i]  <= '0;
                mem_err[i]  <= 1'b0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= wr_data;
                mem_len[wr_ptr]  <= push_len;
                mem_err[wr_ptr]  <= push_err;
                wr_ptr <= (wr_ptr == PTR_MAX) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_MAX) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            err_q <= '0;
        end else if (push && push_err && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign bus.pkt_valid = (occ != '0);
    assign bus.pkt_data  = mem_data[rd_ptr];
    assign bus.pkt_len   = mem_len[rd_ptr];
    assign bus.pkt_err   = mem_err[rd_ptr];
    assign bus.err_cnt   = err_q;
endmodule

// File: tb/tb_axis_s_pkt_assembler.sv
// Directed plus randomized bench for axis_s_pkt_assembler against a queue-based
// model of packet framing, FIFO contents and the error counter.
module tb_axis_s_pkt_assembler;
    localparam int P = 4;
    localparam int D = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    axis_s_pkt_assembler_if #(.PKT_BYTES(P)) bus ();

    axis_s_pkt_assembler #(.PKT_BYTES(P), .FIFO_DEPTH(D)) dut (
        .s_axis_aclk   (clk),
        .s_axis_aresetn(rst_n),
        .bus           (bus.slave)
    );

    typedef struct {
        logic [8*P-1:0] data;
        logic [3:0]     len;
        logic           err;
    } pkt_t;

    pkt_t       mq[$];
    logic [7:0] cur[$];
    bit         disc;
    int         merr;
    int         total = 0;
    int         bad = 0;
    bit         last_acc;
    bit         rnd_rdy = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        cur.delete();
        disc = 1'b0;
        merr = 0;
    endtask

    // One clock: compare against the model, let the edge happen, advance the model.
    task automatic cycle();
        bit         m_rdy, acc, pp, l;
        logic [7:0] d;
        pkt_t       p;
        m_rdy = disc || (mq.size() < D);
        chk("tready", bus.s_axis_tready, m_rdy);
        chk("pkt_valid", bus.pkt_valid, mq.size() != 0);
        chk("err_cnt", bus.err_cnt, (merr > 255) ? 255 : merr);
        if (mq.size() != 0) begin
            chk("pkt_data", bus.pkt_data, mq[0].data);
            chk("pkt_len", bus.pkt_len, mq[0].len);
            chk("pkt_err", bus.pkt_err, mq[0].err);
        end
        acc = bus.s_axis_tvalid && m_rdy;
        pp  = (mq.size() != 0) && bus.pkt_ready;
        d   = bus.s_axis_tdata;
        l   = bus.s_axis_tlast;
        @(posedge clk);
        if (pp) void'(mq.pop_front());
        if (acc) begin
            if (disc) begin
                if (l) disc = 1'b0;
            end else begin
                cur.push_back(d);
                if (l || cur.size() == P) begin
                    p.data = '0;
                    foreach (cur[i]) p.data[8*i +: 8] = cur[i];
                    p.len = 4'(cur.size());
                    p.err = !(l && cur.size() == P);
                    mq.push_back(p);
                    if (p.err) merr++;
                    disc = !l;
                    cur.delete();
                end
            end
        end
        last_acc = acc;
        #2;
    endtask

    task automatic idle(input int n);
        bus.s_axis_tvalid = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send(input logic [7:0] d, input bit l);
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = d;
        bus.s_axis_tlast  = l;
        last_acc = 1'b0;
        for (int n = 0; n < 64; n++) begin
            if (rnd_rdy) bus.pkt_ready = 1'($urandom_range(0, 1));
            cycle();
            if (last_acc) break;
        end
        if (!last_acc) begin
            total++;
            bad++;
            $error("FAIL send_timeout byte=%0h observed=stalled expected=accepted", d);
        end
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.pkt_ready     = 1'b0;
        #1;
        chk("rst_tready", bus.s_axis_tready, 0);
        chk("rst_pkt_valid", bus.pkt_valid, 0);
        chk("rst_pkt_data", bus.pkt_data, 0);
        chk("rst_pkt_len", bus.pkt_len, 0);
        chk("rst_pkt_err", bus.pkt_err, 0);
        chk("rst_err_cnt", bus.err_cnt, 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("tready_after_rst", bus.s_axis_tready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        rst_n = 1'b1;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tlast  = 1'b0;
        bus.pkt_ready     = 1'b0;
        model_reset();
        #1;
        do_reset();

        // Exact-length packet, popped immediately.
        bus.pkt_ready = 1'b1;
        send(8'h00, 0); send(8'h05, 0); send(8'h0A, 0); send(8'h0F, 1);
        chk("s1_valid", bus.pkt_valid, 1);
        chk("s1_data", bus.pkt_data, 32'h0F0A0500);
        chk("s1_len", bus.pkt_len, 4);
        chk("s1_err", bus.pkt_err, 0);
        idle(1);
        chk("s1_popped", bus.pkt_valid, 0);

        // Short packet.
        send(8'h11, 0); send(8'h22, 1);
        chk("s2_data", bus.pkt_data, 32'h00002211);
        chk("s2_len", bus.pkt_len, 2);
        chk("s2_err", bus.pkt_err, 1);
        idle(1);
        chk("s2_err_cnt", bus.err_cnt, 1);

        // Overlong packet: tail dropped, next packet clean.
        send(8'h01, 0); send(8'h02, 0); send(8'h03, 0); send(8'h04, 0);
        chk("s3_data", bus.pkt_data, 32'h04030201);
        chk("s3_len", bus.pkt_len, 4);
        chk("s3_err", bus.pkt_err, 1);
        send(8'h05, 0); send(8'h06, 1);
        chk("s3_dropped", bus.pkt_valid, 0);
        send(8'hA0, 0); send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 1);
        chk("s3_next_data", bus.pkt_data, 32'hA3A2A1A0);
        chk("s3_next_err", bus.pkt_err, 0);
        idle(2);

        // Backpressure: two packets fill the FIFO, third stalls until a pop.
        bus.pkt_ready = 1'b0;
        for (int p = 0; p < 2; p++)
            for (int b = 0; b < P; b++) send(8'(16 * p + b + 8'h30), b == P - 1);
        chk("s4_full_tready", bus.s_axis_tready, 0);
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = 8'h50;
        bus.s_axis_tlast  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("s4_stall", bus.s_axis_tready, 0);
        end
        bus.pkt_ready = 1'b1;
        send(8'h50, 0); send(8'h51, 0); send(8'h52, 0); send(8'h53, 1);
        idle(4);

        // Reset mid-packet.
        send(8'hC0, 0); send(8'hC1, 0);
        do_reset();
        bus.pkt_ready = 1'b1;
        send(8'hD0, 0); send(8'hD1, 0); send(8'hD2, 0); send(8'hD3, 1);
        chk("s5_data", bus.pkt_data, 32'hD3D2D1D0);
        chk("s5_err", bus.pkt_err, 0);
        idle(1);

        // Randomized lengths, gaps and downstream readiness.
        rnd_rdy = 1'b1;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 7);
            for (int b = 0; b < len; b++) begin
                bus.pkt_ready = 1'($urandom_range(0, 1));
                idle($urandom_range(0, 2));
                send(8'($urandom), b == len - 1);
            end
        end
        rnd_rdy = 1'b0;
        bus.pkt_ready = 1'b1;
        idle(4);

        // Error counter saturation.
        do_reset();
        bus.pkt_ready = 1'b1;
        for (int i = 0; i < 260; i++) send(8'(i), 1);
        idle(3);
        chk("sat_err_cnt", bus.err_cnt, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axis_s_pkt_assembler.md
AXIS_S_PKT_ASSEMBLER -- requirements
Module: axis_s_pkt_assembler

Interface
REQ-001 SHALL have parameter PKT_BYTES, default 4, the expected bytes per packet; legal range is 2..8.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, the output packet FIFO depth in packets; it is a power of 2.
REQ-003 SHALL have port s_axis_aclk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 SHALL have port s_axis_aresetn, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port s_axis_tvalid, input, 1 bit: upstream byte valid.
REQ-006 SHALL have port s_axis_tdata, input, 8 bits: upstream byte.
REQ-007 SHALL have port s_axis_tlast, input, 1 bit: last byte of the upstream packet.
REQ-008 SHALL have port s_axis_tready, output, 1 bit: byte accept.
REQ-009 SHALL have port pkt_valid, output, 1 bit: assembled packet available at the FIFO head.
REQ-010 SHALL have port pkt_data, output, 8*PKT_BYTES bits: assembled packet, little-endian.
REQ-011 SHALL have port pkt_len, output, 4 bits: bytes stored in the packet, 1..PKT_BYTES.
REQ-012 SHALL have port pkt_err, output, 1 bit: framing error on this packet.
REQ-013 SHALL have port pkt_ready, input, 1 bit: downstream pops the head packet.
REQ-014 SHALL have port err_cnt, output, 8 bits: saturating count of framing errors.

Function
REQ-015 SHALL accept a byte only when s_axis_tvalid and s_axis_tready are both 1 on a rising edge.
REQ-016 SHALL drive s_axis_tready = 1 when state is DISCARD or the FIFO is not full, else 0; it depends only on registered state.
REQ-017 SHALL implement three states: IDLE (no bytes held), ASSEMBLE (1..PKT_BYTES-1 bytes held), DISCARD (dropping an overlong tail).
REQ-018 SHALL write byte k of a packet (k counted from 0) into pkt_data bits [8k+7:8k]; unwritten bytes SHALL be 0.
REQ-019 Transition IDLE->ASSEMBLE: on an accepted byte with tlast=0.
REQ-020 Transition IDLE->IDLE: on an accepted byte with tlast=1; the block pushes a packet with len=1 and err=1.
REQ-021 Transition ASSEMBLE->IDLE: on an accepted byte with tlast=1; the block pushes a packet with len=count+1 and err=(len!=PKT_BYTES).
REQ-022 Transition ASSEMBLE->DISCARD: when the PKT_BYTES-th byte is accepted with tlast=0; the block pushes a packet with len=PKT_BYTES and err=1.
REQ-023 In DISCARD: accepted bytes SHALL be dropped with no FIFO write; an accepted byte with tlast=1 returns the block to IDLE.
REQ-024 The byte counter SHALL reset to 0 on every push and on entry to IDLE; it never wraps past PKT_BYTES-1.
REQ-025 err_cnt SHALL increment by 1 on each push with err=1 and saturate at 255.
REQ-026 The FIFO SHALL be first-word-fall-through: pkt_valid = not empty, and pkt_data, pkt_len and pkt_err reflect the head entry.
REQ-027 A packet pushed on edge N SHALL appear on pkt_valid after edge N, giving one cycle of latency.
REQ-028 A pop SHALL occur on an edge where pkt_valid and pkt_ready are both 1; pkt_ready while empty SHALL be ignored.
REQ-029 A simultaneous push and pop SHALL leave occupancy unchanged; push while full cannot occur because of REQ-016.
REQ-030 Head outputs SHALL hold stable while pkt_valid=1 and pkt_ready=0.

Reset
REQ-031 While s_axis_aresetn=0, all of the following SHALL hold immediately and asynchronously: state=IDLE, byte counter=0, FIFO empty, pkt_valid=0, pkt_data=0, pkt_len=0, pkt_err=0, err_cnt=0, s_axis_tready=0.
REQ-032 After s_axis_aresetn deasserts, s_axis_tready SHALL be 1 at the first rising edge.
REQ-033 A reset asserted mid-packet SHALL discard any partial assembly and all FIFO contents; the next accepted byte starts a new packet.

Verification
REQ-034 Scenario: 4 beats 0x00,0x05,0x0A,0x0F with tlast on the 4th and pkt_ready=1 -> pkt_data=0x0F0A0500, pkt_len=4, pkt_err=0, pkt_valid=1 for 1 cycle, 1 cycle after the last beat.
REQ-035 Scenario: 2 beats 0x11,0x22 with tlast on the 2nd -> pkt_data=0x00002211, pkt_len=2, pkt_err=1, err_cnt=1.
REQ-036 Scenario: 6 beats 0x01..0x06 with tlast on the 6th -> one packet 0x04030201, len=4, err=1; bytes 0x05 and 0x06 are dropped; the next packet assembles normally.
REQ-037 Scenario: pkt_ready=0 and 3 valid packets sent back-to-back -> 2 packets are stored, s_axis_tready=0 after the 2nd push, and the 3rd packet's first byte stalls until one pop occurs.
REQ-038 Scenario: reset pulsed after 2 bytes of a packet -> pkt_valid=0, then a fresh 4-byte packet yields the correct pkt_data with err=0.
REQ-039 Scenario: 260 short packets -> err_cnt=255 and held at 255.
